axi_rdata_xbar: RTL and testbench

Parametrised AXI read-data (R) channel crossbar between NUM_S slaves and NUM_M masters. Each slave routes its response to the master named in the one-hot upper field of its RID_S. Each master has an independent arbiter, so bursts to different masters proceed in the same cycle. A burst holds its grant from the first unaccepted beat until the RLAST handshake. Beats carrying an illegal master field are drained and counted. The block sits in the AXI interconnect between slave R ports and master R ports.

---
 rtl/axi_rdata_pkg.sv | 51 +++++
 rtl/axi_rdata_xbar_rd_arb.sv | 130 +++++++++++++
 rtl/axi_rdata_xbar.sv | 135 +++++++++++++
 tb/tb_axi_rdata_xbar.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rdata_pkg.sv
// Shared types and decode helpers for the AXI read-data crossbar.
//   gidx_t      : slave/master index type (sized for up to NUM_S_MAX slaves)
//   msel_t      : zero-extended master-select field of a slave RID_S
//   arb_state_e : per-master arbiter state
//   msel_legal  : one-hot check of the master-select field against NUM_M
//   msel_index  : bit position of the (one-hot) master-select field
package axi_rdata_pkg;

    localparam int unsigned NUM_S_MAX  = 16;
    localparam int unsigned GIDX_W     = $clog2(NUM_S_MAX);
    localparam int unsigned MSEL_MAX_W = 16;
    localparam int unsigned MSEL_IDX_W = $clog2(MSEL_MAX_W);

    typedef logic [GIDX_W-1:0]     gidx_t;
    typedef logic [MSEL_MAX_W-1:0] msel_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Legal when exactly one bit is set and it addresses an existing master.
    function automatic logic msel_legal(input msel_t sel, input int unsigned num_m);
        int unsigned ones;
        logic        out_of_range;
        ones         = 0;
        out_of_range = 1'b0;
        for (int unsigned k = 0; k < MSEL_MAX_W; k++) begin
            if (sel[MSEL_IDX_W'(k)]) begin
                ones = ones + 1;
                if (k >= num_m) begin
                    out_of_range = 1'b1;
                end
            end
        end
        return (ones == 1) && !out_of_range;
    endfunction

    // Only meaningful when msel_legal() is true.
    function automatic gidx_t msel_index(input msel_t sel);
        gidx_t idx;
        idx = '0;
        for (int unsigned k = 0; k < MSEL_MAX_W; k++) begin
            if (sel[MSEL_IDX_W'(k)]) begin
                idx = GIDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_rdata_xbar_rd_arb.sv
// Per-master R-channel arbiter: IDLE/BURST FSM, slave selection and the
// burst grant register. A burst keeps its grant from its first unaccepted
// beat until the RLAST handshake.
// Selection: fixed priority (highest index wins) by default; round-robin
// with a per-master pointer when AXI_RDATA_RR_EN is defined.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : slaves requesting this master (valid, legal, targeted)
//   s_rvalid    : raw slave RVALID (used while a burst holds the grant)
//   s_rlast     : raw slave RLAST
//   m_rready    : this master's RREADY
//   gnt_vld_c   : a slave is currently granted
//   gnt_idx_c   : index of the granted slave
module rd_arb
    import axi_rdata_pkg::*;
#(
    parameter int unsigned NUM_S = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_S-1:0] req,
    input  logic [NUM_S-1:0] s_rvalid,
    input  logic [NUM_S-1:0] s_rlast,
    input  logic             m_rready,
    output logic             gnt_vld_c,
    output gidx_t            gnt_idx_c
);

    localparam int unsigned IW = $clog2(NUM_S);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic          pick_vld;
    logic [IW-1:0] pick;
`ifdef AXI_RDATA_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   cand;
`endif

    // Index after x, wrapping NUM_S-1 -> 0.
    function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] x);
        if (32'(x) == NUM_S - 1) begin
            return '0;
        end
        return x + IW'(1);
    endfunction

    // Candidate selection among current requests.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
`ifdef AXI_RDATA_RR_EN
        cand = 0;
        for (int unsigned off = 0; off < NUM_S; off++) begin
            cand = (32'(ptr_q) + off) % NUM_S;
            if (!pick_vld && req[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick     = IW'(cand);
            end
        end
`else
        // Later (higher) indices overwrite earlier ones.
        for (int unsigned i = 0; i < NUM_S; i++) begin
            if (req[IW'(i)]) begin
                pick_vld = 1'b1;
                pick     = IW'(i);
            end
        end
`endif
    end

    // Next state, grant register and grant outputs.
    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
`ifdef AXI_RDATA_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = GIDX_W'(pick);
                    if (!(m_rready && s_rlast[pick])) begin
                        state_d = ARB_BURST;
                        gidx_d  = pick;
                    end
`ifdef AXI_RDATA_RR_EN
                    else begin
                        ptr_d = idx_next(pick);
                    end
`endif
                end
            end
            ARB_BURST: begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = GIDX_W'(gidx_q);
                if (s_rvalid[gidx_q] && m_rready && s_rlast[gidx_q]) begin
                    state_d = ARB_IDLE;
`ifdef AXI_RDATA_RR_EN
                    ptr_d   = idx_next(gidx_q);
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gidx_q  <= '0;
`ifdef AXI_RDATA_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
`ifdef AXI_RDATA_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: rtl/axi_rdata_xbar.sv
// AXI read-data (R) channel crossbar, NUM_S slaves to NUM_M masters.
// Each slave's RID_S upper field is a one-hot master select; the lower
// ID_BITS become the master RID. Routing is purely combinational, with one
// independent rd_arb per master. Beats with an illegal master select are
// accepted and dropped; rd_err_cnt counts such bursts (saturating).
// Optional macro AXI_RDATA_RR_EN: round-robin instead of fixed priority.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   s_rid_s/rdata/rresp/rlast/rvalid, s_rready : slave R ports
//   m_rid/rdata/rresp/rlast/rvalid, m_rready   : master R ports
//   rd_err_cnt                    : count of drained illegal-target bursts
module axi_rdata_xbar
    import axi_rdata_pkg::*;
#(
    parameter int unsigned NUM_S     = 6,
    parameter int unsigned NUM_M     = 3,
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned IDS_BITS  = 8,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_S-1:0][IDS_BITS-1:0]      s_rid_s,
    input  logic [NUM_S-1:0][DATA_BITS-1:0]     s_rdata,
    input  logic [NUM_S-1:0][1:0]               s_rresp,
    input  logic [NUM_S-1:0]                    s_rlast,
    input  logic [NUM_S-1:0]                    s_rvalid,
    output logic [NUM_S-1:0]                    s_rready,
    output logic [NUM_M-1:0][ID_BITS-1:0]       m_rid,
    output logic [NUM_M-1:0][DATA_BITS-1:0]     m_rdata,
    output logic [NUM_M-1:0][1:0]               m_rresp,
    output logic [NUM_M-1:0]                    m_rlast,
    output logic [NUM_M-1:0]                    m_rvalid,
    input  logic [NUM_M-1:0]                    m_rready,
    output logic [7:0]                          rd_err_cnt
);

    localparam int unsigned SW    = $clog2(NUM_S);
    localparam int unsigned MW    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_S + 1);

    logic [NUM_S-1:0]             legal_c;
    gidx_t [NUM_S-1:0]            tgt_c;
    logic [NUM_M-1:0][NUM_S-1:0]  req_c;
    logic [NUM_M-1:0]             gnt_vld_c;
    gidx_t [NUM_M-1:0]            gnt_idx_c;
    logic [SW-1:0]                g;
    logic [CNT_W-1:0]             drain_last_c;
    logic [8:0]                   err_sum_c;
    logic [7:0]                   err_cnt_q, err_cnt_d;

    // Target decode and per-master request vectors.
    always_comb begin
        legal_c = '0;
        tgt_c   = '0;
        req_c   = '0;
        for (int unsigned s = 0; s < NUM_S; s++) begin
            legal_c[SW'(s)] = msel_legal(MSEL_MAX_W'(s_rid_s[SW'(s)][IDS_BITS-1:ID_BITS]), NUM_M);
            tgt_c[SW'(s)]   = msel_index(MSEL_MAX_W'(s_rid_s[SW'(s)][IDS_BITS-1:ID_BITS]));
            for (int unsigned m = 0; m < NUM_M; m++) begin
                req_c[MW'(m)][SW'(s)] = s_rvalid[SW'(s)] && legal_c[SW'(s)]
                                        && (tgt_c[SW'(s)] == GIDX_W'(m));
            end
        end
    end

    // One arbiter per master; different masters never stall each other.
    for (genvar gm = 0; gm < NUM_M; gm++) begin : g_arb
        rd_arb #(
            .NUM_S (NUM_S)
        ) u_rd_arb (
            .clk       (clk),
            .rst_n     (rst),
            .req       (req_c[gm]),
            .s_rvalid  (s_rvalid),
            .s_rlast   (s_rlast),
            .m_rready  (m_rready[gm]),
            .gnt_vld_c (gnt_vld_c[gm]),
            .gnt_idx_c (gnt_idx_c[gm])
        );
    end

    // Data muxes and ready return; everything is held off during reset.
    always_comb begin
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = '0;
        m_rlast  = '0;
        m_rvalid = '0;
        s_rready = '0;
        g        = '0;
        if (rst) begin
            for (int unsigned m = 0; m < NUM_M; m++) begin
                if (gnt_vld_c[MW'(m)]) begin
                    g                 = SW'(gnt_idx_c[MW'(m)]);
                    m_rvalid[MW'(m)]  = s_rvalid[g];
                    m_rid[MW'(m)]     = s_rid_s[g][ID_BITS-1:0];
                    m_rdata[MW'(m)]   = s_rdata[g];
                    m_rresp[MW'(m)]   = s_rresp[g];
                    m_rlast[MW'(m)]   = s_rlast[g];
                    s_rready[g]       = s_rready[g] | (m_rready[MW'(m)] & s_rvalid[g]);
                end
            end
            // Illegal targets are always accepted so the slave can drain.
            for (int unsigned s = 0; s < NUM_S; s++) begin
                if (s_rvalid[SW'(s)] && !legal_c[SW'(s)]) begin
                    s_rready[SW'(s)] = 1'b1;
                end
            end
        end
    end

    // Count drained bursts (last beats), saturating at 255.
    always_comb begin
        drain_last_c = '0;
        for (int unsigned s = 0; s < NUM_S; s++) begin
            if (s_rvalid[SW'(s)] && !legal_c[SW'(s)] && s_rlast[SW'(s)]) begin
                drain_last_c = drain_last_c + CNT_W'(1);
            end
        end
        err_sum_c = 9'(err_cnt_q) + 9'(drain_last_c);
        err_cnt_d = (err_sum_c > 9'd255) ? 8'hFF : err_sum_c[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_axi_rdata_xbar.sv
// Self-checking bench for axi_rdata_xbar (NUM_S=6, NUM_M=3, ID 4, ID_S 8).
module tb_axi_rdata_xbar;

    localparam logic [3:0] N = 4'hF;
`ifdef AXI_RDATA_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [5:0][7:0]   s_rid_s;
    logic [5:0][31:0]  s_rdata;
    logic [5:0][1:0]   s_rresp;
    logic [5:0]        s_rlast;
    logic [5:0]        s_rvalid;
    logic [5:0]        s_rready;
    logic [2:0][3:0]   m_rid;
    logic [2:0][31:0]  m_rdata;
    logic [2:0][1:0]   m_rresp;
    logic [2:0]        m_rlast;
    logic [2:0]        m_rvalid;
    logic [2:0]        m_rready;
    logic [7:0]        rd_err_cnt;

    axi_rdata_xbar #(
        .NUM_S(6), .NUM_M(3), .ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32)
    ) dut (
        .clk(clk), .rst(rst),
        .s_rid_s(s_rid_s), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .rd_err_cnt(rd_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus with expected routing; src is {M2,M1,M0}, F = none.
    typedef struct packed {
        logic [5:0]      vld;
        logic [5:0]      last;
        logic [47:0]     rid;
        logic [2:0]      mrdy;
        logic [11:0]     src;
        logic [5:0]      srdy;
        logic [7:0]      err;
    } vec_t;

    vec_t        vq[$];
    int          checks;
    int          failures;
    logic [3:0]  arb_exp [4];

    function automatic vec_t mk(input logic [5:0] vld, input logic [5:0] last,
                                input logic [47:0] rid, input logic [2:0] mrdy,
                                input logic [11:0] src, input logic [5:0] srdy,
                                input logic [7:0] err);
        vec_t v;
        v.vld = vld; v.last = last; v.rid = rid; v.mrdy = mrdy;
        v.src = src; v.srdy = srdy; v.err = err;
        return v;
    endfunction

    function automatic logic [31:0] dat(input int unsigned s, input int unsigned i);
        return {8'hD0, 8'(i), 8'h5A, 8'(s)};
    endfunction

    task automatic chk(input string name, input int unsigned idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic clear_inputs();
        s_rid_s  = '0;
        s_rdata  = '0;
        s_rresp  = '0;
        s_rlast  = '0;
        s_rvalid = '0;
        m_rready = 3'b111;
    endtask

    task automatic apply_and_check(input vec_t v, input int unsigned i);
        logic [47:0] rid;
        logic [3:0]  src;
        logic [2:0]  exp_v;
        int unsigned sv;
        rid = v.rid;
        for (int unsigned s = 0; s < 6; s++) begin
            s_rid_s[3'(s)] = rid[s*8 +: 8];
            s_rdata[3'(s)] = dat(s, i);
            s_rresp[3'(s)] = 2'(s);
        end
        s_rvalid = v.vld;
        s_rlast  = v.last;
        m_rready = v.mrdy;
        #2;
        exp_v = '0;
        for (int unsigned m = 0; m < 3; m++) begin
            src = v.src[m*4 +: 4];
            if (src == N) begin
                chk("m_rid",   i, 64'(m_rid[2'(m)]),   64'(0));
                chk("m_rdata", i, 64'(m_rdata[2'(m)]), 64'(0));
                chk("m_rlast", i, 64'(m_rlast[2'(m)]), 64'(0));
            end else begin
                sv = 32'(src);
                exp_v[2'(m)] = v.vld[3'(sv)];
                chk("m_rid",   i, 64'(m_rid[2'(m)]),   64'(rid[sv*8 +: 4]));
                chk("m_rdata", i, 64'(m_rdata[2'(m)]), 64'(dat(sv, i)));
                chk("m_rresp", i, 64'(m_rresp[2'(m)]), 64'(2'(sv)));
                chk("m_rlast", i, 64'(m_rlast[2'(m)]), 64'(v.last[3'(sv)]));
            end
        end
        chk("m_rvalid",   i, 64'(m_rvalid),   64'(exp_v));
        chk("s_rready",   i, 64'(s_rready),   64'(v.srdy));
        chk("rd_err_cnt", i, 64'(rd_err_cnt), 64'(v.err));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_inputs();
        if (RR) begin
            arb_exp[0] = 4'd1; arb_exp[1] = 4'd3; arb_exp[2] = 4'd5; arb_exp[3] = 4'd1;
        end else begin
            arb_exp[0] = 4'd5; arb_exp[1] = 4'd5; arb_exp[2] = 4'd5; arb_exp[3] = 4'd5;
        end

        // Idle / single beat / next grant immediate (IDLE kept)
        vq.push_back(mk(6'b000000, 6'b000000, 48'h00_00_00_00_00_00, 3'b111, {N, N, N}, 6'b000000, 8'd0));
        vq.push_back(mk(6'b000100, 6'b000100, 48'h00_00_00_21_00_00, 3'b111, {N, 4'd2, N}, 6'b000100, 8'd0));
        vq.push_back(mk(6'b001000, 6'b001000, 48'h00_00_25_00_00_00, 3'b111, {N, 4'd3, N}, 6'b001000, 8'd0));
        // Burst lock: S1 4 beats to M1, stall 2 cycles, S5 arrives mid-burst
        vq.push_back(mk(6'b000010, 6'b000000, 48'h00_00_00_00_27_00, 3'b111, {N, 4'd1, N}, 6'b000010, 8'd0));
        vq.push_back(mk(6'b000010, 6'b000000, 48'h00_00_00_00_27_00, 3'b101, {N, 4'd1, N}, 6'b000000, 8'd0));
        vq.push_back(mk(6'b100010, 6'b100000, 48'h2A_00_00_00_27_00, 3'b101, {N, 4'd1, N}, 6'b000000, 8'd0));
        vq.push_back(mk(6'b100010, 6'b100000, 48'h2A_00_00_00_27_00, 3'b111, {N, 4'd1, N}, 6'b000010, 8'd0));
        vq.push_back(mk(6'b100010, 6'b100000, 48'h2A_00_00_00_27_00, 3'b111, {N, 4'd1, N}, 6'b000010, 8'd0));
        vq.push_back(mk(6'b100010, 6'b100010, 48'h2A_00_00_00_27_00, 3'b111, {N, 4'd1, N}, 6'b000010, 8'd0));
        vq.push_back(mk(6'b100000, 6'b100000, 48'h2A_00_00_00_00_00, 3'b111, {N, 4'd5, N}, 6'b100000, 8'd0));
        // Parallel masters: S0->M0, S3->M2
        vq.push_back(mk(6'b001001, 6'b001001, 48'h00_00_46_00_00_13, 3'b111, {4'd3, N, 4'd0}, 6'b001001, 8'd0));
        vq.push_back(mk(6'b001001, 6'b000000, 48'h00_00_47_00_00_14, 3'b111, {4'd3, N, 4'd0}, 6'b001001, 8'd0));
        vq.push_back(mk(6'b001001, 6'b001001, 48'h00_00_47_00_00_14, 3'b111, {4'd3, N, 4'd0}, 6'b001001, 8'd0));
        // Illegal targets: 3-beat burst with 0011, single beat with 1000
        vq.push_back(mk(6'b010000, 6'b000000, 48'h00_39_00_00_00_00, 3'b111, {N, N, N}, 6'b010000, 8'd0));
        vq.push_back(mk(6'b010000, 6'b000000, 48'h00_39_00_00_00_00, 3'b111, {N, N, N}, 6'b010000, 8'd0));
        vq.push_back(mk(6'b010000, 6'b010000, 48'h00_39_00_00_00_00, 3'b111, {N, N, N}, 6'b010000, 8'd0));
        vq.push_back(mk(6'b010000, 6'b010000, 48'h00_8B_00_00_00_00, 3'b111, {N, N, N}, 6'b010000, 8'd1));
        vq.push_back(mk(6'b000000, 6'b000000, 48'h00_00_00_00_00_00, 3'b111, {N, N, N}, 6'b000000, 8'd2));
        // Drain alongside a stalled legal beat, then its completion
        vq.push_back(mk(6'b010001, 6'b000001, 48'h00_3C_00_00_00_11, 3'b110, {N, N, 4'd0}, 6'b010000, 8'd2));
        vq.push_back(mk(6'b000001, 6'b000001, 48'h00_00_00_00_00_11, 3'b111, {N, N, 4'd0}, 6'b000001, 8'd2));
        // Arbitration: S1, S3, S5 single beats to M0 continuously
        for (int k = 0; k < 4; k++) begin
            vq.push_back(mk(6'b101010, 6'b101010, 48'h15_00_13_00_11_00, 3'b111,
                            {N, N, arb_exp[k]}, 6'(6'd1 << arb_exp[k]), 8'd2));
        end
        vq.push_back(mk(6'b000000, 6'b000000, 48'h00_00_00_00_00_00, 3'b111, {N, N, N}, 6'b000000, 8'd2));

        // Outputs forced low during reset, even with legal and illegal valids
        #1;
        s_rid_s[2] = 8'h21; s_rid_s[4] = 8'h3C;
        s_rvalid   = 6'b010100;
        s_rlast    = 6'b010100;
        #1;
        chk("rst_m_rvalid", 0, 64'(m_rvalid),   64'(0));
        chk("rst_s_rready", 0, 64'(s_rready),   64'(0));
        chk("rst_err",      0, 64'(rd_err_cnt), 64'(0));
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;

        for (int unsigned i = 0; i < 32'(vq.size()); i++) begin
            @(negedge clk);
            apply_and_check(vq[i], i);
        end

        // Saturation: 300 further single-beat illegal bursts from S4
        for (int i = 0; i < 252; i++) begin
            @(negedge clk);
            s_rid_s[4] = 8'h8B; s_rvalid = 6'b010000; s_rlast = 6'b010000;
        end
        @(negedge clk);
        clear_inputs();
        #2;
        chk("err_254", 0, 64'(rd_err_cnt), 64'(254));
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            s_rid_s[4] = 8'h8B; s_rvalid = 6'b010000; s_rlast = 6'b010000;
        end
        @(negedge clk);
        clear_inputs();
        #2;
        chk("err_sat", 0, 64'(rd_err_cnt), 64'(255));

        // Reset in the middle of a 4-beat burst S1 -> M1
        @(negedge clk);
        s_rid_s[1] = 8'h27; s_rvalid = 6'b000010; s_rlast = 6'b000000;
        @(negedge clk);
        #2;
        chk("mid_m_rvalid", 0, 64'(m_rvalid), 64'(3'b010));
        chk("mid_s_rready", 0, 64'(s_rready), 64'(6'b000010));
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_m_rvalid", 0, 64'(m_rvalid),   64'(0));
        chk("mid_rst_s_rready", 0, 64'(s_rready),   64'(0));
        chk("mid_rst_err",      0, 64'(rd_err_cnt), 64'(0));
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s_rid_s[3] = 8'h25; s_rvalid = 6'b001000; s_rlast = 6'b001000;
        #2;
        chk("post_rst_m_rvalid", 0, 64'(m_rvalid), 64'(3'b010));
        chk("post_rst_m_rid",    0, 64'(m_rid[1]), 64'(4'h5));
        chk("post_rst_s_rready", 0, 64'(s_rready), 64'(6'b001000));
        @(negedge clk);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
